// File: rtl/niu_tx_frame_shaper_if.sv
// AXI-Stream beat bundle between the user TX stream, the shaper and the NIU.
interface niu_tx_frame_shaper_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/niu_tx_frame_shaper.sv
// TX frame shaper: pads short frames to MIN_BYTES, truncates frames beyond
// MAX_BYTES (tuser marks the cut), and counts pad/trunc/frame events.
module niu_tx_frame_shaper #(
  parameter int unsigned MIN_BYTES = 60,
  parameter int unsigned MAX_BYTES = 1514,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                    clk156,
  input  logic                    reset,
  niu_tx_frame_shaper_if.slave    s_axis,
  niu_tx_frame_shaper_if.master   m_axis,
  output logic [CNT_W-1:0]        pad_count,
  output logic [CNT_W-1:0]        trunc_count,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned ACC_W  = 14;
  localparam int unsigned LEN_W  = 15;
  localparam int unsigned NIB_W  = 4;

  localparam logic [LEN_W-1:0] MIN_LEN    = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES);
  localparam logic [NIB_W-1:0] PAD_LAST_N = ((MIN_BYTES % 8) == 0) ? NIB_W'(8)
                                                                  : NIB_W'(MIN_BYTES % 8);

  typedef enum logic [1:0] {ST_PASS, ST_PAD, ST_DISCARD} state_e;

  // Keep mask covering the first n bytes (n = 1..8).
  function automatic logic [KEEP_W-1:0] keep_lsbs(input logic [NIB_W-1:0] n);
    logic [KEEP_W:0] m;
    m = (9'(1) << n) - 9'(1);
    return m[KEEP_W-1:0];
  endfunction

  // Zero every data byte whose keep bit is clear.
  function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                  input logic [KEEP_W-1:0] k);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   m_data_q;
  logic [KEEP_W-1:0]   m_keep_q;
  logic                m_valid_q, m_last_q, m_user_q;
  logic [CNT_W-1:0]    pad_cnt_q, trunc_cnt_q, frame_cnt_q;

  logic                load_c, s_ready_c, emit_c;
  logic [DATA_W-1:0]   e_data_c;
  logic [KEEP_W-1:0]   e_keep_c;
  logic                e_last_c, e_user_c;
  logic                pad_inc_c, trunc_inc_c, frame_inc_c;
  logic [NIB_W-1:0]    beat_bytes_c, trim_n_c, pad_n_c;
  logic [LEN_W-1:0]    acc_ext_c, new_len_c, acc_p8_c;

  assign load_c = !m_valid_q || m_axis.tready;

  // Byte accounting for the beat currently offered on the input.
  always_comb begin
    beat_bytes_c = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      beat_bytes_c = beat_bytes_c + NIB_W'(s_axis.tkeep[i]);
    end
    acc_ext_c = LEN_W'(acc_q);
    new_len_c = acc_ext_c + LEN_W'(beat_bytes_c);
    acc_p8_c  = acc_ext_c + LEN_W'(8);
    trim_n_c  = NIB_W'(MAX_LEN - acc_ext_c);
    pad_n_c   = NIB_W'(MIN_LEN - acc_ext_c);
  end

  // Next-state, next output beat and counter-increment decisions.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    s_ready_c   = 1'b0;
    emit_c      = 1'b0;
    e_data_c    = '0;
    e_keep_c    = '0;
    e_last_c    = 1'b0;
    e_user_c    = 1'b0;
    pad_inc_c   = 1'b0;
    trunc_inc_c = 1'b0;
    case (state_q)
      ST_PASS: begin
        s_ready_c = load_c;
        if (s_axis.tvalid && load_c) begin
          emit_c   = 1'b1;
          e_keep_c = s_axis.tkeep;
          e_data_c = mask_data(s_axis.tdata, s_axis.tkeep);
          acc_d    = new_len_c[ACC_W-1:0];
          if (new_len_c >= MAX_LEN && (!s_axis.tlast || new_len_c > MAX_LEN)) begin
            e_keep_c    = keep_lsbs(trim_n_c);
            e_data_c    = mask_data(s_axis.tdata, keep_lsbs(trim_n_c));
            e_last_c    = 1'b1;
            e_user_c    = 1'b1;
            trunc_inc_c = 1'b1;
            acc_d       = '0;
            state_d     = s_axis.tlast ? ST_PASS : ST_DISCARD;
          end else if (s_axis.tlast && new_len_c >= MIN_LEN) begin
            e_last_c = 1'b1;
            acc_d    = '0;
          end else if (s_axis.tlast) begin
            // Short frame: padded end either lands in this beat or in PAD.
            if (MIN_LEN <= acc_p8_c) begin
              e_keep_c  = keep_lsbs(pad_n_c);
              e_last_c  = 1'b1;
              pad_inc_c = 1'b1;
              acc_d     = '0;
            end else begin
              e_keep_c = '1;
              acc_d    = acc_p8_c[ACC_W-1:0];
              state_d  = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (load_c) begin
          emit_c = 1'b1;
          if (MIN_LEN <= acc_p8_c) begin
            e_keep_c  = keep_lsbs(PAD_LAST_N);
            e_last_c  = 1'b1;
            pad_inc_c = 1'b1;
            acc_d     = '0;
            state_d   = ST_PASS;
          end else begin
            e_keep_c = '1;
            acc_d    = acc_p8_c[ACC_W-1:0];
          end
        end
      end
      ST_DISCARD: begin
        s_ready_c = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          acc_d   = '0;
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d = ST_PASS;
        acc_d   = '0;
      end
    endcase
    if (reset) begin
      s_ready_c = 1'b0;
    end
  end

  assign frame_inc_c = emit_c && e_last_c;

  // State, output register stage and saturating statistics.
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q     <= ST_PASS;
      acc_q       <= '0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      pad_cnt_q   <= '0;
      trunc_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (load_c) begin
        m_valid_q <= emit_c;
        if (emit_c) begin
          m_data_q <= e_data_c;
          m_keep_q <= e_keep_c;
          m_last_q <= e_last_c;
          m_user_q <= e_user_c;
        end
      end
      if (pad_inc_c && pad_cnt_q != '1) begin
        pad_cnt_q <= pad_cnt_q + CNT_W'(1);
      end
      if (trunc_inc_c && trunc_cnt_q != '1) begin
        trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
      end
      if (frame_inc_c && frame_cnt_q != '1) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;
  assign pad_count     = pad_cnt_q;
  assign trunc_count   = trunc_cnt_q;
  assign frame_count   = frame_cnt_q;

endmodule
